// File: rtl/arb_pkg.sv
// Shared types and helpers for the system-bus arbiter.
package arb_pkg;

    localparam int N_MASTERS_DEF  = 4;
    localparam int MAX_TENURE_DEF = 16;
    localparam int ONEHOT_W       = 32;

    typedef enum logic [1:0] {
        ARB,
        GRANTED,
        TURN
    } state_t;

    // Wide one-hot; callers size-cast down to their own master count.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: first requester strictly after rr_ptr, wrapping.
module rr_picker
    import arb_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    localparam int IDX_W    = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     sel,
    output logic                 any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        sel = '0;
        any = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = (int'(rr_ptr) + i) % N_MASTERS;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded tenure and a turnaround gap between owners.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_MASTERS  = N_MASTERS_DEF,
    parameter int MAX_TENURE = MAX_TENURE_DEF,
    localparam int IDX_W     = $clog2(N_MASTERS),
    localparam int TEN_W     = $clog2(MAX_TENURE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 bus_idle,
    output logic [N_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]     owner,
    output logic                 owner_valid,
    output logic                 timeout
);

    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TEN_W-1:0]       tenure_q, tenure_d;
    logic                   timeout_q, timeout_d;

    logic [IDX_W-1:0]       sel;
    logic                   any;
    logic [N_MASTERS-1:0]   owner_onehot;
    logic                   other_req;

    rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .sel    (sel),
        .any    (any)
    );

    assign owner_onehot = N_MASTERS'(onehot(32'(owner_q)));
    assign other_req    = |(req & ~owner_onehot);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tenure_d  = tenure_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB: begin
                if (any) begin
                    gnt_d    = N_MASTERS'(onehot(32'(sel)));
                    owner_d  = sel;
                    rr_ptr_d = sel;
                    tenure_d = '0;
                    state_d  = GRANTED;
                end else begin
                    gnt_d = '0;
                end
            end
            GRANTED: begin
                if (tenure_q != TEN_MAX) begin
                    tenure_d = tenure_q + TEN_W'(1);
                end
                // Release wins over preemption, so a simultaneous drop never pulses timeout.
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = TURN;
                end else if (tenure_q == TEN_MAX && other_req) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = TURN;
                end
            end
            TURN: begin
                gnt_d = '0;
                if (bus_idle) begin
                    state_d = ARB;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB;
            end
        endcase
    end

    // NOTE: asynchronous reset drops the grant at once; the bus never waits for a clock to be released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= IDX_W'(N_MASTERS - 1);
            tenure_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            tenure_q  <= tenure_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign owner_valid = |gnt_q;
    assign timeout     = timeout_q;

endmodule
